dram_dump_unit: RTL and testbench
=================================

Name: dram_dump_unit

Overview:
- Synthesisable, parametrised successor to the bench-side DRAM result dump used with the matrix multiplier top.
- Once armed, it waits until all NUM_CORES cores have been idle for QUIET_CYCLES consecutive cycles.
- It then reads a start pointer from DRAM word PTR_ADDR and streams DRAM[start..END_ADDR] out on a valid/ready byte stream.
- Sits beside the MCU on the DRAM read port. Drives a UART/host-capture path in hardware, or a file writer in simulation.

Parameters:
- NUM_CORES, 4, number of core busy inputs.
- ADDR_W, 16, DRAM address width.
- DATA_W, 8, DRAM word width.
- PTR_ADDR, 12, DRAM address that holds the dump start pointer.
- END_ADDR, 511, last address dumped (inclusive).
- QUIET_CYCLES, 2, consecutive all-idle cycles required before the dump starts (min 1).

Ports:
- i_clk, in, 1, clock; all logic is on the rising edge.
- i_rst_n, in, 1, reset; synchronous, active-low.
- i_start, in, 1, arm request; sampled only in IDLE or DONE.
- i_busy, in, NUM_CORES, per-core busy flags.
- o_mem_rd, out, 1, DRAM read strobe (one cycle per read).
- o_mem_addr, out, ADDR_W, DRAM read address.
- i_mem_data, in, DATA_W, DRAM read data, valid exactly 1 cycle after o_mem_rd.
- o_data, out, DATA_W, stream data.
- o_valid, out, 1, stream valid.
- i_ready, in, 1, stream ready.
- o_active, out, 1, high from arm until the dump completes.
- o_done, out, 1, high in DONE; cleared by the next accepted i_start or by reset.
- o_count, out, ADDR_W+1, number of words accepted by the sink in the current or last dump.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-low on i_rst_n.
- Reset values: all outputs 0, state IDLE, quiet counter 0, address register 0.
- States: IDLE, WAIT_IDLE, PTR_RD, PTR_CAP, RD, CAP, OUT, DONE.
- IDLE/DONE: i_start=1 -> WAIT_IDLE, o_active=1, o_done=0, o_count=0, quiet counter=0.
- WAIT_IDLE:
  - If any i_busy bit is 1, the quiet counter clears; otherwise it increments.
  - When the counter reaches QUIET_CYCLES -> PTR_RD.
  - i_busy is not sampled in any other state.
- PTR_RD: o_mem_rd=1, o_mem_addr=PTR_ADDR -> PTR_CAP.
- PTR_CAP: start = zero-extended i_mem_data.
  - start > END_ADDR -> DONE (zero-length dump, o_count=0).
  - Otherwise address register = start -> RD.
- RD: o_mem_rd=1, o_mem_addr=address register -> CAP.
- CAP: o_data <= i_mem_data, o_valid <= 1 -> OUT.
- OUT:
  - o_data and o_valid are held stable until i_ready=1.
  - On a handshake (o_valid & i_ready): o_valid <= 0, o_count += 1.
  - If address == END_ADDR -> DONE. Otherwise address += 1 -> RD.
  - i_ready high outside OUT has no effect.
- DONE: o_active=0, o_done=1; re-arm through i_start.
- Throughput: one word per 3 cycles when i_ready is held high.
- Latency: first o_valid rises 4 cycles after leaving WAIT_IDLE, when start <= END_ADDR.
- o_mem_rd is high for exactly one cycle per read.
- o_mem_addr holds its last value when o_mem_rd=0.
- i_start while o_active=1 is ignored.
- Reset mid-dump: next state is IDLE, o_valid drops the same edge, the partial count is lost.
- Address arithmetic is ADDR_W-bit unsigned. It cannot wrap, because the END_ADDR compare precedes the increment.
- END_ADDR must satisfy END_ADDR < 2^ADDR_W. Checked by an elaboration-time assertion.

Optional Feature:
- Macro: DRAM_DUMP_CHECKSUM_EN.
- Defined:
  - Adds output o_checksum [DATA_W+ADDR_W-1:0]: the modular sum of every accepted word.
  - Cleared when armed, reset value 0.
  - Updated on each handshake; stable in DONE.
- Undefined: the port and adder are absent; everything else is identical.

Test Plan:
- DRAM[12]=0x1F0, END_ADDR=511, i_busy=4'b0000, i_ready=1, pulse i_start:
  - Exactly 16 words are streamed, matching DRAM[0x1F0..0x1FF] in order.
  - o_count=16, o_done=1, o_active=0.
- i_busy=4'b0100 for 50 cycles after arm, then 0, QUIET_CYCLES=2:
  - No o_mem_rd until the 2nd consecutive idle cycle.
  - A single 1-cycle busy glitch restarts the quiet count.
- Backpressure:
  - i_ready toggles 0,0,1 repeatedly; o_data is stable while o_valid=1 and i_ready=0.
  - No word is lost or duplicated; o_count equals the number of handshakes.
- DRAM[12]=0xFF with END_ADDR=0x0FF: one word is dumped.
- DRAM[12]=0x20 with END_ADDR=0x1F: zero words, o_valid never rises, o_done=1, o_count=0.
- i_rst_n=0 for one cycle mid-stream:
  - Next cycle: state IDLE, all outputs 0.
  - A new i_start performs a complete fresh dump.
  - i_start pulsed during an active dump has no effect.
- With DRAM_DUMP_CHECKSUM_EN, words 0x01,0x02,0xFF: o_checksum=0x102 at DONE, and 0 after re-arm.

Source files
------------

// File: rtl/dram_dump_unit.sv
// dram_dump_unit: waits for all cores to go quiet, then streams DRAM[*PTR_ADDR..END_ADDR]
// out on a valid/ready byte stream. Optional checksum via `DRAM_DUMP_CHECKSUM_EN.
//
// Ports:
//   i_clk, i_rst_n     clock, synchronous active-low reset
//   i_start            arm request (IDLE/DONE only)
//   i_busy             per-core busy flags, watched while waiting for quiet
//   o_mem_rd           one-cycle DRAM read strobe
//   o_mem_addr         DRAM read address (holds when o_mem_rd=0)
//   i_mem_data         DRAM read data, one cycle after o_mem_rd
//   o_data, o_valid    stream output
//   i_ready            stream ready
//   o_active, o_done   dump in progress / dump finished
//   o_count            words accepted in the current or last dump
//   o_checksum         modular sum of accepted words (DRAM_DUMP_CHECKSUM_EN only)
module dram_dump_unit #(
    parameter int NUM_CORES    = 4,
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int PTR_ADDR     = 12,
    parameter int END_ADDR     = 511,
    parameter int QUIET_CYCLES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [NUM_CORES-1:0] i_busy,
    output logic                 o_mem_rd,
    output logic [ADDR_W-1:0]    o_mem_addr,
    input  logic [DATA_W-1:0]    i_mem_data,
    output logic [DATA_W-1:0]    o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_active,
    output logic                 o_done,
`ifdef DRAM_DUMP_CHECKSUM_EN
    output logic [DATA_W+ADDR_W-1:0] o_checksum,
`endif
    output logic [ADDR_W:0]      o_count
);

    localparam int QW = $clog2(QUIET_CYCLES + 1);
    localparam logic [ADDR_W-1:0] PTR_A = ADDR_W'(PTR_ADDR);
    localparam logic [ADDR_W-1:0] END_A = ADDR_W'(END_ADDR);

    if (longint'(END_ADDR) >= (longint'(1) << ADDR_W)) begin : g_bad_end
        $error("END_ADDR does not fit in ADDR_W bits");
    end
    if (QUIET_CYCLES < 1) begin : g_bad_quiet
        $error("QUIET_CYCLES must be at least 1");
    end
    if (DATA_W > ADDR_W) begin : g_bad_width
        $error("start pointer wider than address");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_PTR_RD, S_PTR_CAP,
        S_RD, S_CAP, S_OUT, S_DONE
    } state_t;

    state_t              state, state_n;
    logic [QW-1:0]       quiet, quiet_n;
    logic [ADDR_W-1:0]   addr, addr_n;
    logic [ADDR_W-1:0]   last_addr;
    logic [DATA_W-1:0]   data_n;
    logic                valid_n, active_n, done_n;
    logic [ADDR_W:0]     count_n;
    logic [ADDR_W-1:0]   start_ptr;
`ifdef DRAM_DUMP_CHECKSUM_EN
    logic [DATA_W+ADDR_W-1:0] sum_n;
`endif

    // Pointer is a DRAM word, zero-extended into the address space.
    assign start_ptr = ADDR_W'(i_mem_data);

    always_comb begin
        state_n    = state;
        quiet_n    = quiet;
        addr_n     = addr;
        data_n     = o_data;
        valid_n    = o_valid;
        active_n   = o_active;
        done_n     = o_done;
        count_n    = o_count;
`ifdef DRAM_DUMP_CHECKSUM_EN
        sum_n      = o_checksum;
`endif
        o_mem_rd   = 1'b0;
        o_mem_addr = last_addr;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    state_n  = S_WAIT;
                    active_n = 1'b1;
                    done_n   = 1'b0;
                    count_n  = '0;
                    quiet_n  = '0;
`ifdef DRAM_DUMP_CHECKSUM_EN
                    sum_n    = '0;
`endif
                end
            end
            S_WAIT: begin
                if (|i_busy) begin
                    quiet_n = '0;
                end else begin
                    quiet_n = quiet + 1'b1;
                    if (quiet_n == QW'(QUIET_CYCLES)) state_n = S_PTR_RD;
                end
            end
            S_PTR_RD: begin
                o_mem_rd   = 1'b1;
                o_mem_addr = PTR_A;
                state_n    = S_PTR_CAP;
            end
            S_PTR_CAP: begin
                if (start_ptr > END_A) begin
                    state_n  = S_DONE;
                    active_n = 1'b0;
                    done_n   = 1'b1;
                end else begin
                    addr_n  = start_ptr;
                    state_n = S_RD;
                end
            end
            S_RD: begin
                o_mem_rd   = 1'b1;
                o_mem_addr = addr;
                state_n    = S_CAP;
            end
            S_CAP: begin
                data_n  = i_mem_data;
                valid_n = 1'b1;
                state_n = S_OUT;
            end
            S_OUT: begin
                if (i_ready) begin
                    valid_n = 1'b0;
                    count_n = o_count + 1'b1;
`ifdef DRAM_DUMP_CHECKSUM_EN
                    sum_n   = o_checksum + (DATA_W+ADDR_W)'(o_data);
`endif
                    // Compare before increment so addr never wraps.
                    if (addr == END_A) begin
                        state_n  = S_DONE;
                        active_n = 1'b0;
                        done_n   = 1'b1;
                    end else begin
                        addr_n  = addr + 1'b1;
                        state_n = S_RD;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            quiet     <= '0;
            addr      <= '0;
            last_addr <= '0;
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_active  <= 1'b0;
            o_done    <= 1'b0;
            o_count   <= '0;
`ifdef DRAM_DUMP_CHECKSUM_EN
            o_checksum <= '0;
`endif
        end else begin
            state     <= state_n;
            quiet     <= quiet_n;
            addr      <= addr_n;
            last_addr <= o_mem_addr;
            o_data    <= data_n;
            o_valid   <= valid_n;
            o_active  <= active_n;
            o_done    <= done_n;
            o_count   <= count_n;
`ifdef DRAM_DUMP_CHECKSUM_EN
            o_checksum <= sum_n;
`endif
        end
    end

endmodule

// File: tb/tb_dram_dump_unit.sv
// tb_dram_dump_unit: table-driven and randomized bench for dram_dump_unit.
// The expected stream is built from DRAM contents and the start pointer.
module tb_dram_dump_unit;

    localparam int NC = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int PA = 12;
    localparam int EA = 511;
    localparam int QC = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [NC-1:0] busy = '0;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data = '0;
    logic [DW-1:0] data;
    logic          valid;
    logic          ready = 1'b0;
    logic          active;
    logic          done;
    logic [AW:0]   count;
`ifdef DRAM_DUMP_CHECKSUM_EN
    logic [DW+AW-1:0] checksum;
`endif

    always #5 clk = ~clk;

    dram_dump_unit #(
        .NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW),
        .PTR_ADDR(PA), .END_ADDR(EA), .QUIET_CYCLES(QC)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_busy(busy),
        .o_mem_rd(mem_rd), .o_mem_addr(mem_addr), .i_mem_data(mem_data),
        .o_data(data), .o_valid(valid), .i_ready(ready),
        .o_active(active), .o_done(done),
`ifdef DRAM_DUMP_CHECKSUM_EN
        .o_checksum(checksum),
`endif
        .o_count(count)
    );

    logic [DW-1:0] mem [0:1023];
    always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr[9:0]];

    int checks = 0;
    int fails = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [DW-1:0]    exp_q[$];
    logic [AW-1:0]    addr_q[$];
    logic [DW+AW-1:0] exp_sum;
    logic [DW-1:0]    held;
    logic             hold_v = 1'b0;
    logic             vseen = 1'b0;

    // Stream / read-address monitor against the expected queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd) begin
                checks++;
                if (addr_q.size() == 0) begin
                    fails++;
                    $display("FAIL rd_extra: got read at %0h expected none", mem_addr);
                end else begin
                    checks--;
                    chk("rd_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
                end
            end
            if (hold_v && valid) chk("hold_data", 64'(data), 64'(held));
            if (valid) vseen = 1'b1;
            if (valid && ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL word_extra: got %0h expected none", data);
                end else begin
                    checks--;
                    chk("word", 64'(data), 64'(exp_q.pop_front()));
                end
            end
            hold_v = valid && !ready;
            held   = data;
        end else begin
            hold_v = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input int ptr, output int n);
        mem[PA] = DW'(ptr);
        exp_q.delete();
        addr_q.delete();
        addr_q.push_back(AW'(PA));
        exp_sum = '0;
        n = 0;
        for (int a = ptr; a <= EA; a++) begin
            exp_q.push_back(mem[a]);
            addr_q.push_back(AW'(a));
            exp_sum += (DW+AW)'(mem[a]);
            n++;
        end
    endtask

    task automatic arm();
        vseen = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("arm_active", 64'(active), 64'(1));
        chk("arm_done", 64'(done), 64'(0));
        chk("arm_count", 64'(count), 64'(0));
    endtask

    // mode 0: ready high; 1: ready 0,0,1 per word; 2: random ready/busy
    task automatic wait_done(input int mode);
        int n = 0;
        int vhi = 0;
        while (!done && n < 5000) begin
            case (mode)
                0: ready = 1'b1;
                1: begin
                    vhi = valid ? vhi + 1 : 0;
                    ready = (vhi >= 3);
                end
                default: begin
                    ready = 1'($urandom_range(0, 1));
                    busy = ($urandom_range(0, 3) == 0) ? NC'($urandom_range(1, 15)) : '0;
                end
            endcase
            tick();
            n++;
        end
        busy = '0;
        if (!done) begin
            checks++;
            fails++;
            $display("FAIL timeout: got done=0 expected done=1");
        end
    endtask

    task automatic check_done(input int n);
        tick();
        chk("done_count", 64'(count), 64'(n));
        chk("done_flag", 64'(done), 64'(1));
        chk("done_active", 64'(active), 64'(0));
        chk("done_valid", 64'(valid), 64'(0));
        chk("done_left", 64'(exp_q.size() + addr_q.size()), 64'(0));
        if (n == 0) chk("no_valid", 64'(vseen), 64'(0));
`ifdef DRAM_DUMP_CHECKSUM_EN
        chk("checksum", 64'(checksum), 64'(exp_sum));
`endif
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd"}, 64'(mem_rd), 64'(0));
        chk({tag, "_addr"}, 64'(mem_addr), 64'(0));
        chk({tag, "_data"}, 64'(data), 64'(0));
        chk({tag, "_valid"}, 64'(valid), 64'(0));
        chk({tag, "_active"}, 64'(active), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_count"}, 64'(count), 64'(0));
`ifdef DRAM_DUMP_CHECKSUM_EN
        chk({tag, "_sum"}, 64'(checksum), 64'(0));
`endif
    endtask

    typedef struct {
        int ptr;
        int mode;
        int exp_n;
    } vec_t;

    vec_t tbl [5];
    int   n;
    logic rd_seen;

    initial begin
        tbl[0] = '{ptr: 'h1F0, mode: 0, exp_n: 16};
        tbl[1] = '{ptr: 511,   mode: 1, exp_n: 1};
        tbl[2] = '{ptr: 512,   mode: 0, exp_n: 0};
        tbl[3] = '{ptr: 'h1FE, mode: 1, exp_n: 2};
        tbl[4] = '{ptr: 'h1C0, mode: 2, exp_n: 64};

        for (int i = 0; i < 1024; i++) mem[i] = DW'($urandom);

        repeat (3) tick();
        check_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            setup(tbl[i].ptr, n);
            arm();
            wait_done(tbl[i].mode);
            check_done(tbl[i].exp_n);
        end

        // Quiet window: long busy, then a one-cycle glitch.
        setup('h1F8, n);
        busy = 4'b0100;
        arm();
        ready = 1'b1;
        rd_seen = 1'b0;
        repeat (50) begin
            tick();
            if (mem_rd) rd_seen = 1'b1;
        end
        chk("quiet_busy_rd", 64'(rd_seen), 64'(0));
        busy = '0;
        tick();
        chk("quiet_idle1_rd", 64'(mem_rd), 64'(0));
        busy = 4'b0100;
        tick();
        chk("quiet_glitch_rd", 64'(mem_rd), 64'(0));
        busy = '0;
        tick();
        chk("quiet_again1_rd", 64'(mem_rd), 64'(0));
        tick();
        chk("quiet_ptr_rd", 64'(mem_rd), 64'(1));
        chk("quiet_ptr_addr", 64'(mem_addr), 64'(PA));
        repeat (3) tick();
        chk("lat3_valid", 64'(valid), 64'(0));
        tick();
        chk("lat4_valid", 64'(valid), 64'(1));
        wait_done(0);
        check_done(8);

        // Start ignored mid-dump, then reset mid-stream.
        setup('h1C0, n);
        arm();
        ready = 1'b1;
        repeat (20) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        chk("mid_active", 64'(active), 64'(1));
        rst_n = 1'b0;
        tick();
        check_zero("midrst");
        exp_q.delete();
        addr_q.delete();
        rst_n = 1'b1;
        repeat (4) tick();
        check_zero("idle_after_rst");
        setup('h1E0, n);
        arm();
        wait_done(2);
        check_done(32);

        // Randomized dumps.
        for (int i = 0; i < 6; i++) begin
            for (int a = 420; a < 512; a++) mem[a] = DW'($urandom);
            setup($urandom_range(430, 515), n);
            arm();
            wait_done($urandom_range(0, 2));
            check_done(n);
        end

`ifdef DRAM_DUMP_CHECKSUM_EN
        mem[509] = 16'h01;
        mem[510] = 16'h02;
        mem[511] = 16'hFF;
        setup(509, n);
        arm();
        wait_done(0);
        check_done(3);
        chk("sum_0x102", 64'(checksum), 64'h102);
        setup(509, n);
        arm();
        chk("sum_rearm", 64'(checksum), 64'(0));
        wait_done(0);
        check_done(3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
